// File: rtl/ripple_count_extender.sv
// ripple_count_extender
//   Resamples a free-running ripple counter into clk, accepts a value only
//   after two consecutive samples agree, detects wrap-around and extends
//   the count to EXT_W bits with a sticky overflow flag. A req/ack snapshot
//   port captures the extended count for readout logic.
//
//   Optional feature macro: RIPPLE_EXT_MATCH_EN (adds match_val/match).
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous reset, ACTIVE-HIGH despite the name
//   cnt_in      raw ripple count, may be mid-ripple
//   clr         synchronous clear of extender state
//   ext_cnt     {hi, lo} extended count
//   upd         one-cycle pulse when ext_cnt changes
//   ovf         sticky, set when hi wraps from all-ones to zero
//   snap_req    snapshot request, level sampled each cycle
//   snap_ack    consumer accepted snap_data
//   snap_valid  snap_data valid, held until acked
//   snap_data   captured ext_cnt
//   match_val   compare value            (RIPPLE_EXT_MATCH_EN only)
//   match       pulse when ext_cnt reaches match_val via upd (RIPPLE_EXT_MATCH_EN only)
//
// State table
//   ST_INIT  | waiting for first agreed sample to seed lo, hi=0
//   ST_TRACK | following the counter, extending on wrap

module ripple_count_extender #(
  parameter int IN_W  = 4,
  parameter int EXT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  cnt_in,
  input  logic             clr,
  output logic [EXT_W-1:0] ext_cnt,
  output logic             upd,
  output logic             ovf,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             snap_valid,
  output logic [EXT_W-1:0] snap_data
`ifdef RIPPLE_EXT_MATCH_EN
  ,
  input  logic [EXT_W-1:0] match_val,
  output logic             match
`endif
);

  localparam int HI_W = EXT_W - IN_W;

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   s1, s2;
  logic              v1, v2;
  logic [IN_W-1:0]   lo, lo_nxt;
  logic [HI_W-1:0]   hi, hi_nxt;
  logic              upd_nxt, ovf_nxt;
  logic              snap_valid_nxt;
  logic [EXT_W-1:0]  snap_data_nxt;
  logic              stable;

  assign ext_cnt = {hi, lo};

  // v1/v2 mark that s1/s2 hold real samples rather than their reset zeros,
  // so the first accepted value after reset is the actual counter value
  // and not a spurious 0 that would later show up as a step.
  assign stable = (s1 == s2) && v2;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      s1 <= '0;
      s2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state      <= ST_INIT;
      lo         <= '0;
      hi         <= '0;
      upd        <= 1'b0;
      ovf        <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else begin
      state      <= state_nxt;
      lo         <= lo_nxt;
      hi         <= hi_nxt;
      upd        <= upd_nxt;
      ovf        <= ovf_nxt;
      snap_valid <= snap_valid_nxt;
      snap_data  <= snap_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lo_nxt         = lo;
    hi_nxt         = hi;
    upd_nxt        = 1'b0;
    ovf_nxt        = ovf;
    snap_valid_nxt = snap_valid;
    snap_data_nxt  = snap_data;

    if (clr) begin
      state_nxt      = ST_INIT;
      lo_nxt         = '0;
      hi_nxt         = '0;
      ovf_nxt        = 1'b0;
      snap_valid_nxt = 1'b0;
    end else begin
      if (snap_valid && snap_ack) begin
        snap_valid_nxt = 1'b0;
      end
      case (state)
        ST_INIT: begin
          if (stable) begin
            lo_nxt    = s2;
            hi_nxt    = '0;
            state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (stable && (s2 != lo)) begin
            lo_nxt  = s2;
            upd_nxt = 1'b1;
            // a smaller sample can only mean one wrap of the ripple counter
            if (s2 < lo) begin
              hi_nxt = hi + HI_W'(1);
              if (&hi) begin
                ovf_nxt = 1'b1;
              end
            end
          end
          // capture pre-update value; requests during a pending snapshot drop
          if (snap_req && !snap_valid) begin
            snap_valid_nxt = 1'b1;
            snap_data_nxt  = ext_cnt;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

`ifdef RIPPLE_EXT_MATCH_EN
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      match <= 1'b0;
    end else begin
      match <= upd_nxt && ({hi_nxt, lo_nxt} == match_val);
    end
  end
`endif

endmodule

// File: tb/tb_ripple_count_extender.sv
module tb_ripple_count_extender;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  cnt_in;
  logic        clr;
  logic [11:0] ext_cnt;
  logic        upd;
  logic        ovf;
  logic        snap_req;
  logic        snap_ack;
  logic        snap_valid;
  logic [11:0] snap_data;
`ifdef RIPPLE_EXT_MATCH_EN
  logic [11:0] match_val;
  logic        match;
`endif

  ripple_count_extender #(.IN_W(4), .EXT_W(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .ext_cnt    (ext_cnt),
    .upd        (upd),
    .ovf        (ovf),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .snap_valid (snap_valid),
    .snap_data  (snap_data)
`ifdef RIPPLE_EXT_MATCH_EN
    ,
    .match_val  (match_val),
    .match      (match)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] ext;
    logic        ovf;
    logic        m;
    int          at;
  } exp_t;

  exp_t sb[$];

  logic [7:0] exp_hi;
  logic [3:0] exp_lo;
  logic       exp_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every upd pulse must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      if (upd) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_upd: got ext_cnt %0h with no step pending", ext_cnt);
        end else begin
          e = sb.pop_front();
          chk("upd_ext_cnt", 32'(ext_cnt), 32'(e.ext));
          chk("upd_ovf", 32'(ovf), 32'(e.ovf));
          chk("upd_latency_cycle", 32'(cyc), 32'(e.at));
`ifdef RIPPLE_EXT_MATCH_EN
          chk("match_on_upd", 32'(match), 32'(e.m));
`endif
        end
      end
`ifdef RIPPLE_EXT_MATCH_EN
      else if (match) begin
        chk("match_without_upd", 32'(match), 32'd0);
      end
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // settle cnt_in at v and predict the extender reaction
  task automatic step(input logic [3:0] v);
    exp_t e;
    cnt_in = v;
    if (v != exp_lo) begin
      if (v < exp_lo) begin
        if (exp_hi == 8'hFF) exp_ovf = 1'b1;
        exp_hi = exp_hi + 8'd1;
      end
      exp_lo = v;
      e.ext  = {exp_hi, exp_lo};
      e.ovf  = exp_ovf;
      e.m    = ({exp_hi, exp_lo} == 12'h012);
      e.at   = cyc + 3;
      sb.push_back(e);
    end
    wait_cyc(3);
  endtask

  task automatic pulse(input logic req, input logic ack);
    snap_req = req;
    snap_ack = ack;
    wait_cyc(1);
    snap_req = 1'b0;
    snap_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ext_cnt"},    32'(ext_cnt),    32'd0);
    chk({tag, "_upd"},        32'(upd),        32'd0);
    chk({tag, "_ovf"},        32'(ovf),        32'd0);
    chk({tag, "_snap_valid"}, 32'(snap_valid), 32'd0);
    chk({tag, "_snap_data"},  32'(snap_data),  32'd0);
  endtask

  initial begin
    reset_n  = 1'b1;
    cnt_in   = 4'h5;
    clr      = 1'b0;
    snap_req = 1'b0;
    snap_ack = 1'b0;
`ifdef RIPPLE_EXT_MATCH_EN
    match_val = 12'h012;
`endif
    exp_hi  = 8'h00;
    exp_lo  = 4'h5;
    exp_ovf = 1'b0;

    // 1: reset, then acquire 5 without an update pulse
    wait_cyc(3);
    check_all_zero("reset");
    reset_n = 1'b0;
    wait_cyc(4);
    chk("init_acquire", 32'(ext_cnt), 32'h005);

    // 2: single steps through a wrap
    for (int v = 6; v <= 15; v++) step(4'(v));
    step(4'h0);
    chk("after_first_wrap", 32'(ext_cnt), 32'h010);

    // 3: ripple glitch toggling produces no update, then settle at 4
    for (int i = 0; i < 4; i++) begin
      cnt_in = (i % 2 == 0) ? 4'h3 : 4'h7;
      wait_cyc(1);
    end
    chk("glitch_hold", 32'(ext_cnt), 32'h010);
    step(4'h4);
    chk("glitch_settle", 32'(ext_cnt), 32'h014);

    // 4: climb to FFF, wrap to 000 with sticky ovf
    while (exp_hi != 8'hFF) begin
      step(4'hC);
      step(4'h4);
    end
    step(4'hF);
    chk("at_all_ones", 32'(ext_cnt), 32'hFFF);
    chk("ovf_before_wrap", 32'(ovf), 32'd0);
    step(4'h0);
    chk("overflow_wrap_ext", 32'(ext_cnt), 32'h000);
    chk("overflow_wrap_ovf", 32'(ovf), 32'd1);
    step(4'h3);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    step(4'h3);
    chk("idle_no_change", 32'(ext_cnt), 32'h003);

    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    chk("clr_ext_cnt", 32'(ext_cnt), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    exp_hi  = 8'h00;
    exp_lo  = 4'h3;
    exp_ovf = 1'b0;
    wait_cyc(3);
    chk("clr_reacquire", 32'(ext_cnt), 32'h003);

    // 5: snapshot handshake
    step(4'h8);
    step(4'h0);
    step(4'h2);
    step(4'h8);
    step(4'h0);
    step(4'h3);
    chk("pre_snap_ext", 32'(ext_cnt), 32'h023);
    pulse(1'b0, 1'b1);
    chk("ack_while_idle", 32'(snap_valid), 32'd0);
    pulse(1'b1, 1'b0);
    chk("snap_valid_set", 32'(snap_valid), 32'd1);
    chk("snap_data_023", 32'(snap_data), 32'h023);
    step(4'h7);
    pulse(1'b1, 1'b0);
    chk("second_req_ignored", 32'(snap_data), 32'h023);
    chk("still_valid", 32'(snap_valid), 32'd1);
    pulse(1'b1, 1'b1);
    chk("ack_clears_valid", 32'(snap_valid), 32'd0);
    wait_cyc(1);
    chk("req_with_ack_dropped", 32'(snap_valid), 32'd0);
    chk("snap_data_held", 32'(snap_data), 32'h023);
    pulse(1'b1, 1'b0);
    chk("new_snap_data", 32'(snap_data), 32'h027);
    pulse(1'b0, 1'b1);
    chk("new_snap_acked", 32'(snap_valid), 32'd0);

    // 6: run to 1A7, leave a snapshot pending, reset asynchronously
    while (exp_hi != 8'h1A) begin
      step(4'hF);
      step(4'h7);
    end
    chk("at_1a7", 32'(ext_cnt), 32'h1A7);
    pulse(1'b1, 1'b0);
    chk("pending_snap", 32'(snap_valid), 32'd1);
    #2 reset_n = 1'b1;
    #1 check_all_zero("async_reset");
    wait_cyc(2);
    reset_n = 1'b0;
    wait_cyc(4);
    chk("reacquire_after_reset", 32'(ext_cnt), 32'h007);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
